// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial a-b, LSB first, one bit per clock.
// Optional zero/overflow flags are built when SUBTRATOR_FLAGS_EN is defined.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUBTRATOR_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, res;
  logic [CW-1:0] cnt;
  logic c, d, c_nx, last, accept;
  always_comb begin
    d = a_sr[0] ^ b_sr[0] ^ c;
    c_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & c);
    res = {d, r_sr[WIDTH-1:1]};
    last = (state == RUN) && (cnt == CW'(WIDTH - 1));
    accept = (state != RUN) && start;
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      r_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= res;
      c    <= c_nx;
      cnt  <= cnt + CW'(1);
    end
  end
  // results move only on the edge that completes the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (last) begin
      diff   <= res;
      borrow <= c_nx;
    end
  end
`ifdef SUBTRATOR_FLAGS_EN
  logic a_msb, b_msb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last) begin
      zero     <= (res == '0);
      overflow <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
    end
  end
`endif
endmodule

// File: tb/tb_subtrator_serial.sv
// tb_subtrator_serial: randomized and directed checks of subtrator_serial against an arithmetic model.
module tb_subtrator_serial;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic busy, done, borrow;
  int checks = 0, errors = 0;
`ifdef SUBTRATOR_FLAGS_EN
  logic zero, overflow;
`endif

  subtrator_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SUBTRATOR_FLAGS_EN
    , .zero(zero), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_exclusive busy=%0b done=%0b required not both", busy, done);
    end
  end

  logic [W-1:0] m_diff;
  logic m_borrow, m_zero, m_ovf;

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    int sd;
    t = {1'b0, x} - {1'b0, y};
    m_diff = t[W-1:0];
    m_borrow = t[W];
    m_zero = (m_diff == 0);
    sd = $signed(x) - $signed(y);
    m_ovf = (sd > 127) || (sd < -128);
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 4 * W) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    int n, nb;
    model(x, y);
    launch(x, y);
    wait_done(n, nb);
    checks += 4;
    if (n !== W) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, n, W); end
    if (nb !== W) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, nb, W); end
    if (diff !== m_diff) begin errors++; $display("FAIL %s diff %h-%h got=%h exp=%h", name, x, y, diff, m_diff); end
    if (borrow !== m_borrow) begin errors++; $display("FAIL %s borrow %h-%h got=%b exp=%b", name, x, y, borrow, m_borrow); end
`ifdef SUBTRATOR_FLAGS_EN
    checks += 2;
    if (zero !== m_zero) begin errors++; $display("FAIL %s zero %h-%h got=%b exp=%b", name, x, y, zero, m_zero); end
    if (overflow !== m_ovf) begin errors++; $display("FAIL %s overflow %h-%h got=%b exp=%b", name, x, y, overflow, m_ovf); end
`endif
  endtask

  task automatic test_reset;
    #3;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (diff !== '0) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
`ifdef SUBTRATOR_FLAGS_EN
    checks += 2;
    if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", zero); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] held;
    check_op("d_2d_0f", 8'h2D, 8'h0F);
    check_op("d_05_07", 8'h05, 8'h07);
    check_op("d_80_01", 8'h80, 8'h01);
    check_op("d_3c_3c", 8'h3C, 8'h3C);
    check_op("d_2d_0f_b", 8'h2D, 8'h0F);
    held = diff;
    a = 8'h55; b = 8'hAA;
    repeat (3) begin @(posedge clk); #1; end
    checks += 2;
    if (diff !== held) begin errors++; $display("FAIL hold_idle diff got=%h exp=%h", diff, held); end
    if (done !== 1'b0) begin errors++; $display("FAIL idle_no_done got=%b exp=0", done); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      check_op("rand", W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    check_op("edge_00_ff", 8'h00, 8'hFF);
    check_op("edge_7f_80", 8'h7F, 8'h80);
    check_op("edge_ff_00", 8'hFF, 8'h00);
  endtask

  task automatic test_back_to_back;
    int n, nb;
    launch(8'h10, 8'h01);
    for (int i = 0; i < W - 1; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    if (diff !== 8'h0F) begin errors++; $display("FAIL b2b_ignore_start diff got=%h exp=0f", diff); end
    launch(8'hFF, 8'hFF);
    wait_done(n, nb);
    checks += 3;
    if (n + 1 !== W + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", n + 1, W + 1); end
    if (diff !== 8'h00) begin errors++; $display("FAIL b2b_diff got=%h exp=00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL b2b_borrow got=%b exp=0", borrow); end
  endtask

  task automatic test_reset_midrun;
    int seen;
    check_op("pre_abort", 8'h2D, 8'h0F);
    launch(8'h40, 8'h20);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    if (diff !== '0) begin errors++; $display("FAIL abort_diff got=%h exp=00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL abort_borrow got=%b exp=0", borrow); end
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    check_op("post_abort", 8'h09, 8'h03);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
